// File: rtl/mem_arbiter_pkg.sv
// Arbiter-wide types and defaults shared by the I/D memory arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2
  } arb_state_e;

  // Max consecutive D-side grants while an I-side fetch is waiting.
  localparam int unsigned STARVE_LIMIT_DEFAULT = 4;

  // Instruction fetches always move a full word.
  localparam logic [3:0] I_SIDE_MBE = 4'hF;

endpackage : mem_arbiter_pkg

// File: rtl/rv32i_types.sv
// Shared RV32I scalar types used across the memory subsystem.
package rv32i_types;

  typedef logic [31:0] rv32i_word;

endpackage : rv32i_types

// File: rtl/mem_arbiter.sv
// Two-requester (instruction / data) arbiter onto a single memory port.
// D side has priority, bounded by STARVE_LIMIT consecutive grants while
// an instruction fetch is pending.
module mem_arbiter
  import rv32i_types::*;
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  // instruction side
  input  logic       i_read,
  input  rv32i_word  i_addr,
  output rv32i_word  i_rdata,
  output logic       i_resp,
  // data side
  input  logic       d_read,
  input  logic       d_write,
  input  rv32i_word  d_addr,
  input  rv32i_word  d_wdata,
  input  logic [3:0] d_mbe,
  output rv32i_word  d_rdata,
  output logic       d_resp,
  // shared memory port
  output logic       m_read,
  output logic       m_write,
  output rv32i_word  m_addr,
  output rv32i_word  m_wdata,
  output logic [3:0] m_mbe,
  input  rv32i_word  m_rdata,
  input  logic       m_resp
);

  localparam int unsigned CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  rv32i_word        addr_q, addr_d;
  rv32i_word        wdata_q, wdata_d;
  logic [3:0]       mbe_q, mbe_d;
  logic             m_read_q, m_read_d;
  logic             m_write_q, m_write_d;

  logic d_req;
  logic starved;

  assign d_req   = d_read | d_write;
  assign starved = (starve_cnt_q == CNT_MAX);

  // Arbitration decision, request latching and transaction completion.
  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    mbe_d        = mbe_q;
    m_read_d     = m_read_q;
    m_write_d    = m_write_q;

    unique case (state_q)
      IDLE: begin
        if (d_req && !(i_read && starved)) begin
          state_d   = D_BUSY;
          addr_d    = d_addr;
          wdata_d   = d_wdata;
          mbe_d     = d_mbe;
          // A simultaneous read+write is treated as a write.
          m_write_d = d_write;
          m_read_d  = ~d_write;
          // Grant here implies starve_cnt < limit when i_read is high,
          // so the increment saturates at the limit by construction.
          if (i_read) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
          end
        end else if (i_read) begin
          state_d      = I_BUSY;
          addr_d       = i_addr;
          wdata_d      = '0;
          mbe_d        = I_SIDE_MBE;
          m_read_d     = 1'b1;
          m_write_d    = 1'b0;
          starve_cnt_d = '0;
        end
      end
      I_BUSY, D_BUSY: begin
        if (m_resp) begin
          state_d   = IDLE;
          m_read_d  = 1'b0;
          m_write_d = 1'b0;
        end
      end
      default: begin
        state_d   = IDLE;
        m_read_d  = 1'b0;
        m_write_d = 1'b0;
      end
    endcase
  end

  // State and latched-request registers; reset abandons any transaction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      mbe_q        <= '0;
      m_read_q     <= 1'b0;
      m_write_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      mbe_q        <= mbe_d;
      m_read_q     <= m_read_d;
      m_write_q    <= m_write_d;
    end
  end

  assign m_read  = m_read_q;
  assign m_write = m_write_q;
  assign m_addr  = addr_q;
  assign m_wdata = wdata_q;
  assign m_mbe   = mbe_q;

  assign i_resp  = (state_q == I_BUSY) && m_resp;
  assign d_resp  = (state_q == D_BUSY) && m_resp;
  assign i_rdata = m_rdata;
  assign d_rdata = m_rdata;

endmodule : mem_arbiter

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: max consecutive D-side grants while an I-side request is pending.
REQ-002 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports i_read  input  1 and i_addr  input  32: instruction fetch request and address.
REQ-005 SHALL have ports i_rdata  output  32 and i_resp  output  1: fetch data and one-cycle completion pulse.
REQ-006 SHALL have ports d_read  input  1, d_write  input  1, d_addr  input  32, d_wdata  input  32 and d_mbe  input  4: data request.
REQ-007 SHALL have ports d_rdata  output  32 and d_resp  output  1: load data and one-cycle completion pulse.
REQ-008 SHALL have ports m_read  output  1, m_write  output  1, m_addr  output  32, m_wdata  output  32 and m_mbe  output  4: shared memory port.
REQ-009 SHALL have ports m_rdata  input  32 and m_resp  input  1: memory data and completion.

Function
REQ-010 SHALL implement FSM states IDLE, I_BUSY and D_BUSY.
REQ-011 SHALL, in IDLE, with D request (d_read|d_write) and no i_read, go to D_BUSY; with i_read only, go to I_BUSY; with neither, stay in IDLE.
REQ-012 SHALL, in IDLE, with both pending, grant D unless starve_cnt == STARVE_LIMIT, then grant I.
REQ-013 SHALL keep starve_cnt (width $clog2(STARVE_LIMIT+1)), incremented on each D grant while i_read high, saturating at STARVE_LIMIT, and cleared on any I grant.
REQ-014 SHALL latch addr, wdata, mbe and read/write type on the grant edge; m_* outputs are driven only from these latched registers.
REQ-015 SHALL hold m_read or m_write high throughout the BUSY state: m_read for I_BUSY and D_BUSY loads, m_write for D_BUSY stores; both 0 in IDLE.
REQ-016 SHALL, when d_read and d_write are both high at grant, perform a write.
REQ-017 SHALL drive m_mbe = 4'hF for I-side transactions and the latched d_mbe for D-side transactions.
REQ-018 SHALL, in a BUSY state with m_resp high, combinationally pulse i_resp or d_resp (matching the state) for that cycle only, with i_rdata/d_rdata = m_rdata, and return to IDLE on the next edge.
REQ-019 SHALL keep i_resp and d_resp low and ignore m_resp in IDLE.
REQ-020 SHALL drive i_rdata/d_rdata to m_rdata continuously; they are valid only with the matching resp.
REQ-021 SHALL, on request at cycle N in IDLE, assert m_* at cycle N+1; a back-to-back request costs one IDLE bubble cycle.
REQ-022 SHALL NOT sample requester inputs in BUSY states; requesters hold requests until resp.

Reset
REQ-023 SHALL, on rst low, immediately force: state IDLE, starve_cnt 0, m_read/m_write 0, m_addr/m_wdata 0, m_mbe 0, i_resp/d_resp 0.
REQ-024 SHALL abandon any in-flight transaction on reset mid-transaction, and SHALL NOT issue a resp for it after reset release.
REQ-025 SHALL begin arbitration on the first rising edge after rst returns high.

Structure
REQ-026 SHALL use rv32i_word from the shared package rv32i_types.
REQ-027 SHALL declare the FSM state enum and the default STARVE_LIMIT in a shared arbiter package.
REQ-028 SHALL be a single module with no sub-modules; the arbitration decision is one always_comb block.

Verification
REQ-029 SHALL cover: i_read, i_addr=0x60 alone; m_resp 3 cycles later -> m_read=1, m_addr=0x60, m_mbe=F; i_resp 1 cycle; i_rdata=m_rdata.
REQ-030 SHALL cover: simultaneous i_read(0x60) and d_write(0x100, wdata=0xDEADBEEF, mbe=0011) -> D granted first with m_write=1 and m_mbe=0011, then I after one IDLE cycle.
REQ-031 SHALL cover: continuous d_read plus i_read with STARVE_LIMIT=4 -> grants D,D,D,D,I,D…; starve_cnt clears on the I grant.
REQ-032 SHALL cover: d_read and d_write both high -> m_write=1, m_read=0.
REQ-033 SHALL cover: rst low mid D_BUSY, then m_resp high after release -> no d_resp; state IDLE; m_* 0 while rst low.
REQ-034 SHALL cover: m_resp high in IDLE -> no i_resp/d_resp; state unchanged.
